// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider for DIV/DIVU/REM/REMU with RISC-V
// result semantics; one trial subtraction per clock, start/busy/done handshake.
module seq_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] part_rem;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dsr_mag;
    logic            sign_q;
    logic            sign_r;

    logic            dvd_neg;
    logic            dsr_neg;
    logic            div_zero;
    logic            overflow;
    logic            last;
    logic [XLEN:0]   shifted_rem;
    logic [XLEN:0]   trial;
    logic            fits;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;

    // Operand classification, evaluated on the start edge only.
    assign dvd_neg  = is_signed & dividend[XLEN-1];
    assign dsr_neg  = is_signed & divisor[XLEN-1];
    assign div_zero = (divisor == '0);
    assign overflow = is_signed && (dividend == MIN_NEG) && (divisor == '1);

    // dvd_mag doubles as the quotient shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    assign shifted_rem = {part_rem, dvd_mag[XLEN-1]};
    assign trial       = shifted_rem - {1'b0, dsr_mag};
    assign fits        = ~trial[XLEN];
    assign rem_step    = fits ? trial[XLEN-1:0] : shifted_rem[XLEN-1:0];
    assign quo_step    = {dvd_mag[XLEN-2:0], fits};
    assign last        = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (div_zero || overflow) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            part_rem  <= '0;
            dvd_mag   <= '0;
            dsr_mag   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        sign_r <= dvd_neg;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end else if (overflow) begin
                            quotient  <= MIN_NEG;
                            remainder <= '0;
                        end else begin
                            dvd_mag  <= dvd_neg ? -dividend : dividend;
                            dsr_mag  <= dsr_neg ? -divisor : divisor;
                            part_rem <= '0;
                            count    <= CW'(XLEN - 1);
                        end
                    end
                end
                CALC: begin
                    part_rem <= rem_step;
                    dvd_mag  <= quo_step;
                    count    <= count - CW'(1);
                    if (last) begin
                        quotient  <= sign_q ? -quo_step : quo_step;
                        remainder <= sign_r ? -rem_step : rem_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider; results and handshake timing are
// predicted from plain integer division and the documented cycle counts.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // Handshake: start is honoured only at a rising edge while idle; operands
    // are captured on that edge; done is a one-cycle pulse with results valid.
    seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 0;
    bit          pending  = 0;
    int          done_cyc = 0;
    int          acc_cyc  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait expired at cycle %0d", name, cyc);
    endtask

    // Reference: {quotient, remainder} from wide integer arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint na, nb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b, input logic s);
        return (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy, exp_done;
            logic [63:0] e;
            exp_busy = pending && (cyc >= acc_cyc) && (cyc < done_cyc);
            exp_done = pending && (cyc == done_cyc);
            chk("busy", {63'd0, busy}, {63'd0, exp_busy});
            chk("done", {63'd0, done}, {63'd0, exp_done});
            if (exp_done) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
                chk("quotient", {32'd0, quotient}, {32'd0, e[63:32]});
                chk("remainder", {32'd0, remainder}, {32'd0, e[31:0]});
                pending = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int t = 0;
        while (pending && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (pending) timeout_fail("wait_idle");
        @(negedge clk);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        wait_idle();
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        exp_q.push_back(model(a, b, s));
        acc_cyc  = cyc;
        done_cyc = cyc + (is_special(a, b, s) ? 0 : 32);
        pending  = 1;
    endtask

    task automatic poke_start();
        dividend  = $urandom;
        divisor   = $urandom_range(1, 9);
        is_signed = 1'($urandom_range(0, 1));
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_cycle(input int target, input string name);
        int t = 0;
        while (cyc != target && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (cyc != target) timeout_fail(name);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, b;
        logic        s;

        // Model pins, hand-computed.
        chk("model_100_7", model(32'd100, 32'd7, 1'b0), {32'd14, 32'd2});
        chk("model_ffff_16", model(32'hFFFF_FFFF, 32'd16, 1'b0), {32'h0FFF_FFFF, 32'd15});
        chk("model_m7_2", model(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        chk("model_7_m2", model(32'd7, 32'hFFFF_FFFE, 1'b1), {32'hFFFF_FFFD, 32'd1});
        chk("model_ovf", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h8000_0000, 32'd0});
        chk("model_div0", model(32'h1234, 32'd0, 1'b1), {32'hFFFF_FFFF, 32'h1234});

        // Reset held with start asserted: nothing accepted.
        rst_n     = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_quotient", {32'd0, quotient}, 64'd0);
        chk("rst_remainder", {32'd0, remainder}, 64'd0);
        start  = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1;

        // Directed cases.
        start_op(32'd100, 32'd7, 1'b0);
        start_op(32'hFFFF_FFFF, 32'd16, 1'b0);
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        start_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        start_op(32'h1234, 32'd0, 1'b0);
        start_op(32'h1234, 32'd0, 1'b1);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // start pulsed during CALC and during the DONE cycle is ignored.
        start_op(32'd5000, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        poke_start();
        wait_cycle(done_cyc, "wait_done_poke");
        poke_start();
        start_op(32'd81, 32'd9, 1'b0);

        // Reset at iteration 10 aborts; no done for that operation.
        start_op(32'd999_999, 32'd37, 1'b0);
        wait_cycle(acc_cyc + 10, "wait_iter10");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        pending = 0;
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("abort_quotient", {32'd0, quotient}, 64'd0);
        chk("abort_remainder", {32'd0, remainder}, 64'd0);
        rst_n = 1'b1;
        start_op(32'd1000, 32'd10, 1'b0);

        // Randomized operations with biased divisor choices.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            start_op(a, b, s);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
